// File: rtl/crp16_mem_arbiter.sv
// Port-B arbiter for the CRP16 data RAM: the CPU always wins, and a one-entry host request waits for a free cycle.
// Optional starvation relief (wait counter driving cpu_hold_req) is enabled by defining CRP16_ARB_STARVE_EN.
module crp16_mem_arbiter #(
    parameter int STARVE_LIMIT = 16
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        cpu_req,
    input  logic        cpu_wren,
    input  logic [15:0] cpu_addr,
    input  logic [15:0] cpu_wdata,
    output logic [15:0] cpu_rdata,
    input  logic        host_req,
    input  logic        host_we,
    input  logic [15:0] host_addr,
    input  logic [15:0] host_wdata,
    output logic        host_ready,
    output logic        host_valid,
    output logic [15:0] host_rdata,
    output logic        cpu_hold_req,
    output logic [15:0] address_b,
    output logic [15:0] data_b,
    output logic        wren_b,
    input  logic [15:0] q_b
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic        w_accept;
    logic        w_grant;

    logic        r_req_we;
    logic [15:0] r_req_addr;
    logic [15:0] r_req_wdata;
    logic        r_host_ready;
    logic        r_host_valid;
    logic [15:0] r_host_rdata;

    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        w_grant  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (host_req) begin
                    w_accept = 1'b1;
                    w_next   = S_WAIT;
                end
            end
            S_WAIT: begin
                if (!cpu_req) begin
                    w_grant = 1'b1;
                    w_next  = S_DONE;
                end
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // The CPU owns the port whenever it asks; otherwise the idle default never writes.
    always_comb begin
        address_b = cpu_addr;
        data_b    = cpu_wdata;
        wren_b    = 1'b0;
        if (cpu_req) begin
            wren_b = cpu_wren;
        end else if (w_grant) begin
            address_b = r_req_addr;
            data_b    = r_req_wdata;
            wren_b    = r_req_we;
        end
    end

    assign cpu_rdata = q_b;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state      <= S_IDLE;
            r_host_ready <= 1'b1;
            r_host_valid <= 1'b0;
            r_host_rdata <= 16'h0000;
            r_req_we     <= 1'b0;
            r_req_addr   <= 16'h0000;
            r_req_wdata  <= 16'h0000;
        end else begin
            r_state      <= w_next;
            r_host_ready <= (w_next == S_IDLE);
            r_host_valid <= (w_next == S_DONE);
            if (w_accept) begin
                r_req_we    <= host_we;
                r_req_addr  <= host_addr;
                r_req_wdata <= host_wdata;
            end
            if (w_grant && !r_req_we) begin
                r_host_rdata <= q_b;
            end
        end
    end

    assign host_ready = r_host_ready;
    assign host_valid = r_host_valid;
    assign host_rdata = r_host_rdata;

`ifdef CRP16_ARB_STARVE_EN
    localparam logic [7:0] LP_LIMIT = 8'(STARVE_LIMIT);

    logic [7:0] r_wait_cnt;
    logic [7:0] w_cnt_inc;
    logic       w_blocked;
    logic       r_hold;

    assign w_blocked = (r_state == S_WAIT) && cpu_req;
    assign w_cnt_inc = (r_wait_cnt == 8'hFF) ? r_wait_cnt : r_wait_cnt + 8'd1;

    // Hold is raised on the same edge the counter reaches the limit, and dropped on the grant edge.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_wait_cnt <= 8'h00;
            r_hold     <= 1'b0;
        end else begin
            if (w_accept) begin
                r_wait_cnt <= 8'h00;
            end else if (w_blocked) begin
                r_wait_cnt <= w_cnt_inc;
            end
            if (w_grant) begin
                r_hold <= 1'b0;
            end else if (w_blocked && (w_cnt_inc >= LP_LIMIT)) begin
                r_hold <= 1'b1;
            end
        end
    end

    assign cpu_hold_req = r_hold;
`else
    assign cpu_hold_req = 1'b0;
`endif

endmodule
